// File: rtl/ddc_mix_cic_if.sv
// I/Q down-converter stream bundle: qualified ADC/LO input samples in, decimated I/Q strobe out.
interface ddc_mix_cic_if #(
    parameter int DATA_W = 8,
    parameter int LO_W   = 8,
    parameter int OUT_W  = 16
);
    logic                     i_valid;
    logic signed [DATA_W-1:0] i_adc;
    logic signed [LO_W-1:0]   i_sin;
    logic signed [LO_W-1:0]   i_cos;
    logic signed [OUT_W-1:0]  o_i;
    logic signed [OUT_W-1:0]  o_q;
    logic                     o_valid;

    modport master (output i_valid, i_adc, i_sin, i_cos, input o_i, o_q, o_valid);
    modport slave  (input i_valid, i_adc, i_sin, i_cos, output o_i, o_q, o_valid);
endinterface

// File: rtl/ddc_mix_cic.sv
// Quadrature mixer followed by a 3-stage, R=2^DEC_LOG2 CIC decimator on each of I and Q.
// Optional round-half-up with positive saturation on the output when DDC_ROUND_EN is defined.
module ddc_mix_cic #(
    parameter int DATA_W   = 8,
    parameter int LO_W     = 8,
    parameter int DEC_LOG2 = 4,
    parameter int OUT_W    = 16
) (
    input logic          clk,
    input logic          rst_n,
    ddc_mix_cic_if.slave bus
);
    localparam int STAGES = 3;
    localparam int ACC_W  = DATA_W + LO_W + STAGES * DEC_LOG2;
    localparam int PROD_W = DATA_W + LO_W;
    localparam int SHIFT  = ACC_W - OUT_W;
    localparam int R      = 1 << DEC_LOG2;

    logic signed [DATA_W-1:0] adc_p0;
    logic signed [LO_W-1:0]   sin_p0, cos_p0;
    logic                     vld_p0;
    logic signed [PROD_W-1:0] prod_c, prod_s;
    logic signed [ACC_W-1:0]  pi_p1, pq_p1;
    logic                     vld_p1;
    logic signed [ACC_W-1:0]  i_int1_p2, i_int2_p2, i_int3_p2;
    logic signed [ACC_W-1:0]  q_int1_p2, q_int2_p2, q_int3_p2;
    logic [DEC_LOG2-1:0]      cnt_p2;
    logic                     dec_stb_p2;
    logic signed [ACC_W-1:0]  i_d1, i_d2, i_d3, q_d1, q_d2, q_d3;
    logic signed [ACC_W-1:0]  i_c1, i_c2, i_c3, q_c1, q_c2, q_c3;

    function automatic logic signed [OUT_W-1:0] out_sel(input logic signed [ACC_W-1:0] c);
`ifdef DDC_ROUND_EN
        logic signed [ACC_W:0] half;
        logic signed [ACC_W:0] s;
        half = (SHIFT > 0) ? ((ACC_W+1)'(1) << (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;
        s    = (ACC_W+1)'(c) + half;
        // Only a positive overflow is possible when adding the half-LSB.
        if (!s[ACC_W] && s[ACC_W-1])
            return {1'b0, {(OUT_W-1){1'b1}}};
        return OUT_W'(s >>> SHIFT);
`else
        return OUT_W'(c >>> SHIFT);
`endif
    endfunction

    assign prod_c = adc_p0 * cos_p0;
    assign prod_s = adc_p0 * sin_p0;

    // p0: input capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_p0 <= '0;
            sin_p0 <= '0;
            cos_p0 <= '0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= bus.i_valid;
            if (bus.i_valid) begin
                adc_p0 <= bus.i_adc;
                sin_p0 <= bus.i_sin;
                cos_p0 <= bus.i_cos;
            end
        end
    end

    // p1: mixer products, sign-extended to the CIC width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pi_p1  <= '0;
            pq_p1  <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                pi_p1 <= ACC_W'(prod_c);
                pq_p1 <= -ACC_W'(prod_s);
            end
        end
    end

    // p2: integrators (modulo 2^ACC_W) and decimation counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_int1_p2  <= '0;
            i_int2_p2  <= '0;
            i_int3_p2  <= '0;
            q_int1_p2  <= '0;
            q_int2_p2  <= '0;
            q_int3_p2  <= '0;
            cnt_p2     <= '0;
            dec_stb_p2 <= 1'b0;
        end else begin
            dec_stb_p2 <= vld_p1 && (cnt_p2 == DEC_LOG2'(R - 1));
            if (vld_p1) begin
                i_int1_p2 <= i_int1_p2 + pi_p1;
                i_int2_p2 <= i_int2_p2 + i_int1_p2;
                i_int3_p2 <= i_int3_p2 + i_int2_p2;
                q_int1_p2 <= q_int1_p2 + pq_p1;
                q_int2_p2 <= q_int2_p2 + q_int1_p2;
                q_int3_p2 <= q_int3_p2 + q_int2_p2;
                cnt_p2    <= cnt_p2 + DEC_LOG2'(1);
            end
        end
    end

    always_comb begin
        i_c1 = i_int3_p2 - i_d1;
        i_c2 = i_c1 - i_d2;
        i_c3 = i_c2 - i_d3;
        q_c1 = q_int3_p2 - q_d1;
        q_c2 = q_c1 - q_d2;
        q_c3 = q_c2 - q_d3;
    end

    // p3: combs at the decimated rate and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_d1        <= '0;
            i_d2        <= '0;
            i_d3        <= '0;
            q_d1        <= '0;
            q_d2        <= '0;
            q_d3        <= '0;
            bus.o_i     <= '0;
            bus.o_q     <= '0;
            bus.o_valid <= 1'b0;
        end else begin
            bus.o_valid <= dec_stb_p2;
            if (dec_stb_p2) begin
                i_d1    <= i_int3_p2;
                i_d2    <= i_c1;
                i_d3    <= i_c2;
                q_d1    <= q_int3_p2;
                q_d2    <= q_c1;
                q_d3    <= q_c2;
                bus.o_i <= out_sel(i_c3);
                bus.o_q <= out_sel(q_c3);
            end
        end
    end
endmodule
